fp_norm_round: RTL and testbench

- Post-divide normalise/round stage of the IEEE-754 single-precision divider; the consumer and decoder of the leading-zero count produced by the divider's priority encoder.
- Takes the raw 2L+2-bit quotient mantissa, its leading-zero count, sign and intermediate biased exponent.
- Decodes the count into a left shift and exponent correction, rounds to nearest-even, and packs a 1+E+L-bit IEEE word with overflow/underflow flags.
- Multi-cycle FSM with valid/ready handshakes on both sides.

---
 rtl/fp_div_pkg.sv | 26 ++
 rtl/lz_shift_decoder.sv | 30 +++
 rtl/fp_norm_round.sv | 138 +++++++++++++
 tb/tb_fp_norm_round.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared widths, FSM states and the packed result word for the divider's normalise/round stage.
package fp_div_pkg;

   localparam int L       = 23;
   localparam int E       = 8;
   localparam int BIAS    = 2**(E-1) - 1;
   localparam int EXP_MAX = 2*BIAS + 1;
   localparam int MW      = 2*L + 2;
   localparam int LZW     = $clog2(MW);
   localparam int EW      = E + 2;
   localparam int DW      = 1 + E + L;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      ROUND,
      OUT
   } state_e;

   typedef struct packed {
      logic         sign;
      logic [E-1:0] exp;
      logic [L-1:0] frac;
   } fp_word_t;

endpackage

// File: rtl/lz_shift_decoder.sv
// Turns a leading-zero count into a one-hot shift select and left-justifies the mantissa.
// The hidden bit lands in bit MW-1 and is dropped, so only the bits below it are returned.
module lz_shift_decoder
   import fp_div_pkg::*;
(
   input  logic [LZW-1:0] lz_i,
   input  logic [MW-1:0]  mant_i,
   output logic [MW-2:0]  mant_o
);

   logic [MW-1:0] shiftSel;

   always_comb begin
      shiftSel = '0;
      for (int i = 0; i < MW; i++) begin
         shiftSel[i] = (lz_i == LZW'(i));
      end
   end

   // Counts beyond MW-1 select nothing and yield an all-zero mantissa.
   always_comb begin
      mant_o = '0;
      for (int i = 0; i < MW; i++) begin
         if (shiftSel[i]) begin
            mant_o = mant_o | (MW-1)'(mant_i << i);
         end
      end
   end

endmodule

// File: rtl/fp_norm_round.sv
// Post-divide normalise and round-to-nearest-even stage producing a packed single-precision word.
// One operand in flight at a time: IDLE -> NORM -> ROUND -> OUT.
module fp_norm_round
   import fp_div_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           in_sign,
   input  logic [EW-1:0]  in_exp,
   input  logic [MW-1:0]  in_mant,
   input  logic [LZW-1:0] in_lz,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [DW-1:0]  out_data,
   output logic           out_overflow,
   output logic           out_underflow
);

   localparam logic signed [EW-1:0] EXP_TOP  = EW'(EXP_MAX);
   localparam logic signed [EW-1:0] EXP_ZERO = '0;

   state_e               state_q;
   logic                 sign_q;
   logic                 zero_q;
   logic signed [EW-1:0] exp_q;
   logic signed [EW-1:0] expNorm_q;
   logic [MW-1:0]        mant_q;
   logic [MW-2:0]        mantNorm_q;
   logic [LZW-1:0]       lz_q;
   fp_word_t             outData_q;
   logic                 outValid_q;
   logic                 overflow_q;
   logic                 underflow_q;

   logic [MW-2:0]        mantShifted;
   logic signed [EW-1:0] expShifted;

   lz_shift_decoder u_lzShiftDecoder (
      .lz_i   (lz_q),
      .mant_i (mant_q),
      .mant_o (mantShifted)
   );

   assign expShifted = exp_q - $signed({{(EW-LZW){1'b0}}, lz_q});

   logic [L-1:0]         frac;
   logic                 guard;
   logic                 sticky;
   logic                 roundUp;
   logic [L:0]           fracSum;
   logic signed [EW-1:0] expRound;
   fp_word_t             result_d;
   logic                 overflow_d;
   logic                 underflow_d;

   // A fraction carry-out leaves an all-zero fraction and bumps the exponent.
   always_comb begin
      frac        = mantNorm_q[2*L:L+1];
      guard       = mantNorm_q[L];
      sticky      = |mantNorm_q[L-1:0];
      roundUp     = guard & (sticky | frac[0]);
      fracSum     = {1'b0, frac} + {{L{1'b0}}, roundUp};
      expRound    = expNorm_q + $signed({{(EW-1){1'b0}}, fracSum[L]});
      result_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      result_d.sign = sign_q;
      if (!zero_q) begin
         if (expRound >= EXP_TOP) begin
            result_d.exp = E'(EXP_MAX);
            overflow_d   = 1'b1;
         end else if (expRound <= EXP_ZERO) begin
            underflow_d  = 1'b1;
         end else begin
            result_d.exp  = expRound[E-1:0];
            result_d.frac = fracSum[L-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         outValid_q  <= 1'b0;
         outData_q   <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         sign_q      <= 1'b0;
         zero_q      <= 1'b0;
         exp_q       <= '0;
         expNorm_q   <= '0;
         mant_q      <= '0;
         mantNorm_q  <= '0;
         lz_q        <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready) begin
                  sign_q  <= in_sign;
                  exp_q   <= in_exp;
                  mant_q  <= in_mant;
                  lz_q    <= in_lz;
                  state_q <= NORM;
               end
            end
            NORM: begin
               mantNorm_q <= mantShifted;
               expNorm_q  <= expShifted;
               zero_q     <= (mant_q == '0);
               state_q    <= ROUND;
            end
            ROUND: begin
               outData_q   <= result_d;
               overflow_q  <= overflow_d;
               underflow_q <= underflow_d;
               outValid_q  <= 1'b1;
               state_q     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  outValid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready      = (state_q == IDLE) && !rst;
   assign out_valid     = outValid_q;
   assign out_data      = outData_q;
   assign out_overflow  = overflow_q;
   assign out_underflow = underflow_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed vector bench for fp_norm_round: table of operands with hand-computed IEEE words,
// plus backpressure and mid-flight reset sequences.
module tb_fp_norm_round;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [47:0] in_mant;
   logic [5:0]  in_lz;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_overflow;
   logic        out_underflow;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct {
      logic        sgn;
      logic [9:0]  exp;
      logic [47:0] mant;
      logic [5:0]  lz;
      logic [31:0] data;
      logic        ovf;
      logic        unf;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   fp_norm_round dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_sign       (in_sign),
      .in_exp        (in_exp),
      .in_mant       (in_mant),
      .in_lz         (in_lz),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_overflow  (out_overflow),
      .out_underflow (out_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A nonzero mantissa must always arrive with a count that stays inside the mantissa.
   always @(posedge clk) begin
      if (in_valid && in_ready && in_mant != '0) begin
         assert (in_lz <= 6'd47) else $error("[TB] illegal in_lz %0d with nonzero mantissa", in_lz);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Presents one operand, then follows it to the OUT state and checks latency and result.
   task automatic applyStimulus(input vec_t v, input string tag);
      int cycle;
      @(negedge clk);
      checkOutput({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
      in_sign  = v.sgn;
      in_exp   = v.exp;
      in_mant  = v.mant;
      in_lz    = v.lz;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cycle = 1;
      while (!out_valid && cycle < 8) begin
         checkOutput({tag, " in_ready busy"}, 64'(in_ready), 64'd0);
         @(posedge clk);
         #1;
         cycle++;
      end
      checkOutput({tag, " latency"}, 64'(cycle), 64'd3);
      checkOutput({tag, " in_ready at out"}, 64'(in_ready), 64'd0);
      checkOutput({tag, " data"}, 64'(out_data), 64'(v.data));
      checkOutput({tag, " overflow"}, 64'(out_overflow), 64'(v.ovf));
      checkOutput({tag, " underflow"}, 64'(out_underflow), 64'(v.unf));
   endtask

   task automatic finishHandshake(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
      checkOutput({tag, " in_ready back"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 10'd127, 48'h800000_000000, 6'd0,  32'h3F800000, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 10'd150, 48'h000001_000000, 6'd23, 32'h3F800000, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 10'd137, 48'h002000_000000, 6'd10, 32'h3F800000, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 10'd127, 48'h800000_800000, 6'd0,  32'h3F800000, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 10'd127, 48'h800000_800001, 6'd0,  32'h3F800001, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 10'd127, 48'hFFFFFF_800000, 6'd0,  32'h40000000, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 10'd127, 48'h800000_7FFFFF, 6'd0,  32'h3F800000, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 10'd300, 48'h800000_000000, 6'd0,  32'h7F800000, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 10'd5,   48'h002000_000000, 6'd10, 32'h80000000, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 10'd127, 48'h000000_000000, 6'd0,  32'h80000000, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 10'h3FD, 48'h000000_000000, 6'd40, 32'h00000000, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 10'd254, 48'h800000_000000, 6'd0,  32'h7F000000, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 10'd255, 48'h800000_000000, 6'd0,  32'h7F800000, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 10'd1,   48'h800000_000000, 6'd0,  32'h00800000, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 10'd0,   48'h800000_000000, 6'd0,  32'h00000000, 1'b0, 1'b1};
      vecs[15] = '{1'b0, 10'd254, 48'hFFFFFF_800000, 6'd0,  32'h7F800000, 1'b1, 1'b0};
      vecs[16] = '{1'b1, 10'd128, 48'hC00000_000000, 6'd0,  32'hC0400000, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 10'd130, 48'h000000_C00001, 6'd24, 32'h35400001, 1'b0, 1'b0};
      vecs[18] = '{1'b0, 10'd300, 48'h000000_000000, 6'd5,  32'h00000000, 1'b0, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = '0;
      in_mant   = '0;
      in_lz     = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset out_data", 64'(out_data), 64'd0);
      checkOutput("reset overflow", 64'(out_overflow), 64'd0);
      checkOutput("reset underflow", 64'(out_underflow), 64'd0);
      checkOutput("reset in_ready held", 64'(in_ready), 64'd0);
      rst = 1'b0;
      #1;
      checkOutput("reset in_ready released", 64'(in_ready), 64'd1);

      for (int i = 0; i < NV; i++) begin
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
         finishHandshake($sformatf("vec%0d", i));
      end

      // Stall the consumer for five cycles; the result and flags must not move.
      out_ready = 1'b0;
      applyStimulus(vecs[7], "stall");
      repeat (5) begin
         @(posedge clk);
         #1;
         checkOutput("stall out_valid", 64'(out_valid), 64'd1);
         checkOutput("stall data", 64'(out_data), 64'(vecs[7].data));
         checkOutput("stall overflow", 64'(out_overflow), 64'd1);
         checkOutput("stall in_ready", 64'(in_ready), 64'd0);
      end
      finishHandshake("stall");

      // Leave a nonzero result in the output register, then abort the next operand in ROUND.
      applyStimulus(vecs[16], "prereset");
      finishHandshake("prereset");
      @(negedge clk);
      in_sign  = vecs[5].sgn;
      in_exp   = vecs[5].exp;
      in_mant  = vecs[5].mant;
      in_lz    = vecs[5].lz;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("abort in_ready during rst", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("abort out_valid", 64'(out_valid), 64'd0);
      checkOutput("abort out_data", 64'(out_data), 64'd0);
      checkOutput("abort in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      checkOutput("abort no stray result", 64'(out_valid), 64'd0);

      applyStimulus(vecs[5], "b2b0");
      finishHandshake("b2b0");
      applyStimulus(vecs[8], "b2b1");
      finishHandshake("b2b1");
      applyStimulus(vecs[17], "b2b2");
      finishHandshake("b2b2");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
